// File: rtl/esn_pkg.sv
// ---------------------------------------------------------------------------
// esn_pkg
// Shared definitions for the echo-state-network datapath blocks.
//   ESN_DATA_W / ESN_FRAC : default sample width and fractional bits,
//                           common to esn_top and its monitors.
//   ACCUM / DRAIN / OUT   : esn_mse_monitor FSM state encoding.
//   Q_ONE                 : 1.0 in the default Q format.
//   MSE_MAX               : largest reportable (positive) MSE value.
// ---------------------------------------------------------------------------
package esn_pkg;

  localparam int ESN_DATA_W = 32;
  localparam int ESN_FRAC   = 16;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  localparam logic [ESN_DATA_W-1:0] Q_ONE   = 1 << ESN_FRAC;
  localparam logic [ESN_DATA_W-1:0] MSE_MAX = {1'b0, {(ESN_DATA_W-1){1'b1}}};

endpackage

// File: rtl/esn_sq_err.sv
// ---------------------------------------------------------------------------
// esn_sq_err
// Two-stage squared-error pipeline.
//   Stage 1: diff = est - target, DATA_W+1 bits signed (cannot overflow).
//   Stage 2: sq   = (diff*diff) >> FRAC, unsigned, 2*(DATA_W+1)-FRAC bits.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (valid bits only)
//   in_valid     : est/target pair enters stage 1 this cycle
//   est, target  : signed Q-format samples
//   sq           : stage-2 squared error
//   sq_valid     : sq holds a valid result
//   busy         : any stage still holds a valid sample
// ---------------------------------------------------------------------------
module esn_sq_err
  import esn_pkg::*;
#(
  parameter  int DATA_W = ESN_DATA_W,
  parameter  int FRAC   = ESN_FRAC,
  localparam int SQ_W   = 2*(DATA_W+1)-FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] est,
  input  logic signed [DATA_W-1:0] target,
  output logic        [SQ_W-1:0]   sq,
  output logic                     sq_valid,
  output logic                     busy
);

  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = 2 * DIFF_W;

  logic signed [DIFF_W-1:0] diff_p1;
  logic                     vld_p1;
  logic        [SQ_W-1:0]   sq_p2;
  logic                     vld_p2;

  // Square is always non-negative, so the product can be treated as unsigned
  // before dropping the FRAC fractional bits of the doubled scale.
  function automatic logic [SQ_W-1:0] square_q(input logic signed [DIFF_W-1:0] d);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(d) * PROD_W'(d);
    return SQ_W'($unsigned(p) >> FRAC);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    // stage 1: difference
    if (in_valid) diff_p1 <= DIFF_W'(est) - DIFF_W'(target);
    // stage 2: scaled square
    if (vld_p1) sq_p2 <= square_q(diff_p1);
  end

  assign sq       = sq_p2;
  assign sq_valid = vld_p2;
  assign busy     = vld_p1 | vld_p2;

endmodule

// File: rtl/esn_mse_monitor.sv
// ---------------------------------------------------------------------------
// esn_mse_monitor
// Accumulates squared error between esn_top's readout estimate and a target
// over windows of 2^LOG2_WIN accepted samples and reports the window MSE.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   est_valid/est_ready, est, target : input pair handshake and data
//   mse_valid/mse_ready, mse, sat    : result handshake, MSE (unsigned Q),
//                                      saturation flag for that window
//   sample_cnt        : samples accepted in the current window
// ---------------------------------------------------------------------------
module esn_mse_monitor
  import esn_pkg::*;
#(
  parameter int DATA_W   = ESN_DATA_W,
  parameter int FRAC     = ESN_FRAC,
  parameter int LOG2_WIN = 4,
  parameter int ACC_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     est_valid,
  input  logic signed [DATA_W-1:0] est,
  input  logic signed [DATA_W-1:0] target,
  output logic                     est_ready,
  output logic                     mse_valid,
  input  logic                     mse_ready,
  output logic        [DATA_W-1:0] mse,
  output logic                     sat,
  output logic      [LOG2_WIN:0]   sample_cnt
);

  localparam int SQ_W  = 2*(DATA_W+1)-FRAC;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_WIN) - 1);
  localparam logic [ACC_W-1:0] MSE_LIM  = ACC_W'(1) << (DATA_W-1);

  logic [1:0]        state, state_next;
  logic              accept, handshake;
  logic [SQ_W-1:0]   sq_p2;
  logic              vld_p2, pipe_busy;
  logic              vld_p3;
  logic [ACC_W-1:0]  acc_p3;
  logic              sat_acc_p3;
  logic [ACC_W:0]    acc_sum;
  logic [DATA_W:0]   mse_res;

  // Saturating add; MSB of the result flags that the accumulator clipped.
  // Assumes SQ_W <= ACC_W so a single sample always fits.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [SQ_W-1:0]  s);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W+1)'(s);
    if (sum[ACC_W]) sum = {1'b1, {ACC_W{1'b1}}};
    return sum;
  endfunction

  // Window mean with clip to the largest positive DATA_W value; MSB flags clip.
  function automatic logic [DATA_W:0] mse_sat(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] q;
    q = a >> LOG2_WIN;
    if (q >= MSE_LIM) return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    return {1'b0, q[DATA_W-1:0]};
  endfunction

  esn_sq_err #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_sq_err (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .est      (est),
    .target   (target),
    .sq       (sq_p2),
    .sq_valid (vld_p2),
    .busy     (pipe_busy)
  );

  assign accept    = est_valid && est_ready && (state == ACCUM);
  assign mse_valid = (state == OUT);
  assign handshake = mse_valid && mse_ready;
  assign acc_sum   = acc_add(acc_p3, sq_p2);
  assign mse_res   = mse_sat(acc_p3);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && sample_cnt == LAST_CNT) state_next = DRAIN;
      // vld_p3 keeps DRAIN one cycle past the final accumulate so acc is settled
      DRAIN:   if (!pipe_busy && !vld_p3) state_next = OUT;
      OUT:     if (mse_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // stage 3: accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3     <= 1'b0;
      acc_p3     <= '0;
      sat_acc_p3 <= 1'b0;
    end else begin
      vld_p3 <= vld_p2;
      if (handshake) begin
        acc_p3     <= '0;
        sat_acc_p3 <= 1'b0;
      end else if (vld_p2) begin
        acc_p3     <= acc_sum[ACC_W-1:0];
        sat_acc_p3 <= sat_acc_p3 | acc_sum[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      est_ready  <= 1'b0;
      sample_cnt <= '0;
      mse        <= '0;
      sat        <= 1'b0;
    end else begin
      state     <= state_next;
      est_ready <= (state_next == ACCUM);
      if (handshake)   sample_cnt <= '0;
      else if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
      if (state == DRAIN && state_next == OUT) begin
        mse <= mse_res[DATA_W-1:0];
        sat <= sat_acc_p3 | mse_res[DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_esn_mse_monitor.sv
// ---------------------------------------------------------------------------
// tb_esn_mse_monitor
// Randomized stimulus with a scoreboard: accepted pairs are collected by a
// window model that computes the expected MSE with wide integer arithmetic;
// a negedge monitor checks handshake outputs every cycle and pops expected
// results whenever the DUT completes a result handshake.
// ---------------------------------------------------------------------------
module tb_esn_mse_monitor;
  import esn_pkg::*;

  localparam int WIN = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               est_valid;
  logic signed [31:0] est, target;
  logic               est_ready;
  logic               mse_valid;
  logic               mse_ready;
  logic        [31:0] mse;
  logic               sat;
  logic        [4:0]  sample_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic signed [31:0] win_est[$];
  logic signed [31:0] win_tgt[$];
  logic        [32:0] sb_q[$];
  logic        [32:0] exp_r;
  int                 phase    = 0;
  int                 wait_cnt = 0;
  int                 m_cnt    = 0;
  logic               m_ready  = 1'b0;
  logic               m_valid  = 1'b0;
  logic               m_sat    = 1'b0;
  logic        [31:0] m_mse    = '0;
  logic        [31:0] last_mse = '0;
  logic               last_sat = 1'b0;
  int                 results  = 0;

  always #5 clk = ~clk;

  esn_mse_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .est_valid  (est_valid),
    .est        (est),
    .target     (target),
    .est_ready  (est_ready),
    .mse_valid  (mse_valid),
    .mse_ready  (mse_ready),
    .mse        (mse),
    .sat        (sat),
    .sample_cnt (sample_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Expected {sat, mse} for the collected window, straight from the rules:
  // mean over the window of ((est-target)^2 >> FRAC), with clipping.
  function automatic logic [32:0] model_window();
    logic signed [127:0] d;
    logic        [127:0] sq, acc, m;
    logic                s;
    acc = '0;
    s   = 1'b0;
    for (int i = 0; i < win_est.size(); i++) begin
      d   = win_est[i];
      d   = d - win_tgt[i];
      sq  = $unsigned(d * d) >> 16;
      acc = acc + sq;
      if (acc > 128'hFFFF_FFFF_FFFF_FFFF) begin
        acc = 128'hFFFF_FFFF_FFFF_FFFF;
        s   = 1'b1;
      end
    end
    m = acc >> 4;
    if (m >= 128'h8000_0000) begin
      m = 128'h7FFF_FFFF;
      s = 1'b1;
    end
    return {s, m[31:0]};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check("rst_est_ready", 64'(est_ready), 64'(0));
      check("rst_mse_valid", 64'(mse_valid), 64'(0));
      check("rst_sample_cnt", 64'(sample_cnt), 64'(0));
      check("rst_mse", 64'(mse), 64'(0));
      check("rst_sat", 64'(sat), 64'(0));
      phase   = 0;
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_cnt   = 0;
      m_mse   = '0;
      m_sat   = 1'b0;
      win_est.delete();
      win_tgt.delete();
      sb_q.delete();
    end else begin
      check("est_ready", 64'(est_ready), 64'(m_ready));
      check("mse_valid", 64'(mse_valid), 64'(m_valid));
      check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
      check("mse_hold", 64'(mse), 64'(m_mse));
      check("sat_hold", 64'(sat), 64'(m_sat));
      if (mse_valid && mse_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual mse=0x%0h required=no result t=%0t", mse, $time);
        end else begin
          exp_r = sb_q.pop_front();
          check("result_mse", 64'(mse), 64'(exp_r[31:0]));
          check("result_sat", 64'(sat), 64'(exp_r[32]));
          last_mse = mse;
          last_sat = sat;
          results++;
        end
      end
      // advance model to the values expected after the coming edge
      case (phase)
        0: begin
          m_ready = 1'b1;
          if (est_valid && est_ready) begin
            win_est.push_back(est);
            win_tgt.push_back(target);
            m_cnt++;
            if (m_cnt == WIN) begin
              sb_q.push_back(model_window());
              win_est.delete();
              win_tgt.delete();
              phase    = 1;
              wait_cnt = 4;
              m_ready  = 1'b0;
            end
          end
        end
        1: begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            phase   = 2;
            m_valid = 1'b1;
            if (sb_q.size() > 0) {m_sat, m_mse} = sb_q[0];
          end
        end
        default: begin
          if (mse_ready) begin
            phase   = 0;
            m_valid = 1'b0;
            m_ready = 1'b1;
            m_cnt   = 0;
          end
        end
      endcase
    end
  end

  task automatic send(input logic [31:0] e, input logic [31:0] t, input int max_bubble);
    int nb;
    int waited;
    nb = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
    est_valid = 1'b0;
    repeat (nb) begin
      @(posedge clk);
      #1;
    end
    est_valid = 1'b1;
    est       = e;
    target    = t;
    waited    = 0;
    @(negedge clk);
    while (!est_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!est_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual est_ready=0 required=1 t=%0t", $time);
    end
    @(posedge clk);
    #1;
    est_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk);
    while (!(mse_valid && mse_ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!(mse_valid && mse_ready)) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual no handshake required handshake t=%0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_last(input string name, input logic [31:0] e_mse, input logic e_sat);
    check({name, "_mse"}, 64'(last_mse), 64'(e_mse));
    check({name, "_sat"}, 64'(last_sat), 64'(e_sat));
  endtask

  initial begin
    logic [31:0] b, d, e, t;
    int n, res0;
    rst       = 1'b1;
    est_valid = 1'b0;
    est       = '0;
    target    = '0;
    mse_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // equal samples
    for (int i = 0; i < WIN; i++) send(32'h0003_0000, 32'h0003_0000, 0);
    wait_result();
    check_last("t1", 32'h0, 1'b0);

    // alternating +1.0 / -1.0 with bubbles
    for (int i = 0; i < WIN; i++) begin
      b = $urandom_range(0, 32'h00FF_FFFF);
      d = (i % 2 == 0) ? Q_ONE : -Q_ONE;
      send(b, b - d, 3);
    end
    wait_result();
    check_last("t2", 32'h0001_0000, 1'b0);

    // diff 2.0, result held while consumer stalls
    mse_ready = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      b = $urandom_range(0, 32'h00FF_FFFF);
      send(b, b - 32'h0002_0000, 0);
    end
    n = 0;
    @(negedge clk);
    while (!mse_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t3_mse_valid_seen", 64'(mse_valid), 64'(1));
    repeat (5) @(negedge clk);
    check("t3_held_mse", 64'(mse), 64'h0004_0000);
    @(posedge clk);
    #1 mse_ready = 1'b1;
    @(posedge clk);
    #1;
    check_last("t3", 32'h0004_0000, 1'b0);
    @(negedge clk);
    check("t3_ready_after", 64'(est_ready), 64'(1));

    // output saturation, then a clean window
    for (int i = 0; i < WIN; i++) send(32'h7FFF_FFFF, 32'h8000_0000, 1);
    wait_result();
    check_last("t4", MSE_MAX, 1'b1);
    for (int i = 0; i < WIN; i++) begin
      b = $urandom;
      send(b, b, 1);
    end
    wait_result();
    check_last("t4b", 32'h0, 1'b0);

    // reset mid-window discards partial state
    res0 = results;
    for (int i = 0; i < 7; i++) send(32'h0005_0000, 32'h0001_0000, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      b = $urandom_range(0, 32'h00FF_FFFF);
      send(b, b - Q_ONE, 2);
    end
    wait_result();
    check_last("t5", 32'h0001_0000, 1'b0);
    check("t5_result_count", 64'(results), 64'(res0 + 1));

    // est_valid held high with changing data during DRAIN/OUT
    for (int i = 0; i < WIN; i++) send($urandom, $urandom, 0);
    est_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(mse_valid && mse_ready) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      est    = $urandom;
      target = $urandom;
      @(negedge clk);
    end
    @(posedge clk);
    #1 est_valid = 1'b0;

    // random windows over the full range
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WIN; i++) begin
        e = $urandom;
        t = (w == 0) ? $urandom : e + $urandom_range(0, 32'h0FFF_FFFF);
        send(e, t, 2);
      end
      wait_result();
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
